spacecraft_avalon_responder: RTL and testbench



---
 rtl/spacecraft_avalon_responder.sv | 152 +++++++++++++++
 tb/tb_spacecraft_avalon_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spacecraft_avalon_responder.sv
// Avalon-MM responder for the spacecraft peripheral: LED/blink control, scratch register
// and a telemetry FIFO written by the bus master and drained over a valid/ready stream.
module spacecraft_avalon_responder #(
    parameter int FIFO_DEPTH    = 8,
    parameter bit STALL_ON_FULL = 1'b1,
    parameter int BLINK_W       = 24
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [3:0]  leds_readdata,
    output logic [31:0] tlm_data,
    output logic        tlm_valid,
    input  logic        tlm_ready
);

    localparam int               AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]      COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);

    typedef enum logic [2:0] {
        ADDR_LED      = 3'd0,
        ADDR_BLINK    = 3'd1,
        ADDR_STATUS   = 3'd2,
        ADDR_TLM_PUSH = 3'd3,
        ADDR_SCRATCH  = 3'd4
    } reg_addr_e;

    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        fill_count;
    logic               fifo_full, fifo_empty, ovf;
    logic               push, pop, drop;
    logic               wr_led, wr_blink, wr_status, wr_tlm, wr_scratch;
    logic [4:0]         led_reg;
    logic [BLINK_W-1:0] blink_period, blink_count;
    logic               blink_phase, blink_active;
    logic [31:0]        scratch, read_word;

    assign wr_led     = avs_write && (avs_address == ADDR_LED);
    assign wr_blink   = avs_write && (avs_address == ADDR_BLINK);
    assign wr_status  = avs_write && (avs_address == ADDR_STATUS);
    assign wr_tlm     = avs_write && (avs_address == ADDR_TLM_PUSH);
    assign wr_scratch = avs_write && (avs_address == ADDR_SCRATCH);

    assign fifo_full  = (fill_count == FULL_COUNT);
    assign fifo_empty = (fill_count == '0);
    assign tlm_valid  = !fifo_empty;
    assign tlm_data   = fifo_mem[rd_ptr];
    assign pop        = tlm_valid && tlm_ready;

    // A pop in the same cycle frees the slot, so a full FIFO only stalls or drops without one.
    assign avs_waitrequest = STALL_ON_FULL && wr_tlm && fifo_full && !pop;
    assign push            = wr_tlm && !avs_waitrequest && (!fifo_full || pop);
    assign drop            = !STALL_ON_FULL && wr_tlm && fifo_full && !pop;

    assign blink_active = led_reg[4] && (blink_period != '0);

    // NOTE: storage is deliberately not reset; emptiness is tracked by the pointers and count,
    // which keeps the array free to map onto RAM.
    always_ff @(posedge clk_clk) begin
        if (push) fifo_mem[wr_ptr] <= avs_writedata;
    end

    // NOTE: every state element is updated with non-blocking assignments so all registers
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fill_count <= fill_count + COUNT_ONE;
                2'b01:   fill_count <= fill_count - COUNT_ONE;
                default: ;
            endcase
            if (drop)
                ovf <= 1'b1;
            else if (wr_status && avs_writedata[18])
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            led_reg       <= '0;
            blink_period  <= '0;
            scratch       <= '0;
            blink_count   <= '0;
            blink_phase   <= 1'b1;
            leds_readdata <= '0;
        end else begin
            if (wr_led)     led_reg      <= avs_writedata[4:0];
            if (wr_blink)   blink_period <= avs_writedata[BLINK_W-1:0];
            if (wr_scratch) scratch      <= avs_writedata;

            // Reprogramming restarts the blink cycle on the lit half.
            if (wr_led || wr_blink || !blink_active) begin
                blink_count <= '0;
                blink_phase <= 1'b1;
            end else if (blink_count == blink_period - BLINK_ONE) begin
                blink_count <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_count <= blink_count + BLINK_ONE;
            end

            leds_readdata <= blink_active ? (led_reg[3:0] & {4{blink_phase}}) : led_reg[3:0];
        end
    end

    // NOTE: the read mux assigns a default first so no path leaves it unassigned (no latch).
    always_comb begin
        read_word = '0;
        case (avs_address)
            ADDR_LED:     read_word[4:0] = led_reg;
            ADDR_BLINK:   read_word[BLINK_W-1:0] = blink_period;
            ADDR_STATUS: begin
                read_word[AW:0] = fill_count;
                read_word[16]   = fifo_full;
                read_word[17]   = fifo_empty;
                read_word[18]   = ovf;
            end
            ADDR_SCRATCH: read_word = scratch;
            default:      ;
        endcase
    end

    // Registers are read before this edge's writes land, so read+write returns the old value.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= read_word;
        end
    end

endmodule

// File: tb/tb_spacecraft_avalon_responder.sv
// Directed bench for spacecraft_avalon_responder: a stalling instance and a dropping
// instance share stimulus, and sel routes bus strobes and observed outputs to one of them.
module tb_spacecraft_avalon_responder;

    logic        clk = 1'b0;
    logic        reset_reset;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic        tlm_ready;
    logic        sel;

    logic        wr1, wr2, rvalid1, rvalid2, tvalid1, tvalid2;
    logic [31:0] rdata1, rdata2, tdata1, tdata2;
    logic [3:0]  leds1, leds2;

    logic        waitreq, rvalid, tvalid;
    logic [31:0] rdata, tdata;
    logic [3:0]  leds;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spacecraft_avalon_responder #(.FIFO_DEPTH(8), .STALL_ON_FULL(1'b1), .BLINK_W(24)) dut_stall (
        .clk_clk(clk), .reset_reset(reset_reset), .avs_address(avs_address),
        .avs_read(avs_read && !sel), .avs_write(avs_write && !sel), .avs_writedata(avs_writedata),
        .avs_waitrequest(wr1), .avs_readdata(rdata1), .avs_readdatavalid(rvalid1),
        .leds_readdata(leds1), .tlm_data(tdata1), .tlm_valid(tvalid1), .tlm_ready(tlm_ready)
    );

    spacecraft_avalon_responder #(.FIFO_DEPTH(8), .STALL_ON_FULL(1'b0), .BLINK_W(24)) dut_drop (
        .clk_clk(clk), .reset_reset(reset_reset), .avs_address(avs_address),
        .avs_read(avs_read && sel), .avs_write(avs_write && sel), .avs_writedata(avs_writedata),
        .avs_waitrequest(wr2), .avs_readdata(rdata2), .avs_readdatavalid(rvalid2),
        .leds_readdata(leds2), .tlm_data(tdata2), .tlm_valid(tvalid2), .tlm_ready(tlm_ready)
    );

    assign waitreq = sel ? wr2     : wr1;
    assign rdata   = sel ? rdata2  : rdata1;
    assign rvalid  = sel ? rvalid2 : rvalid1;
    assign tdata   = sel ? tdata2  : tdata1;
    assign tvalid  = sel ? tvalid2 : tvalid1;
    assign leds    = sel ? leds2   : leds1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the write until waitrequest drops; a stall past the budget is reported as a failure.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bit done = 1'b0;
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            #1;
            if (!waitreq) done = 1'b1;
            tick();
        end
        avs_write = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL write_accept addr=%0d: waitrequest still 1 after 64 cycles, required 0", a);
        end
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = rdata; v = rvalid;
    endtask

    task automatic test_reset();
        n_total++; if (leds !== 4'h0)     $display("FAIL reset_leds: got %h want 0", leds);       else n_pass++;
        n_total++; if (tvalid !== 1'b0)   $display("FAIL reset_tvalid: got %b want 0", tvalid);   else n_pass++;
        n_total++; if (rvalid !== 1'b0)   $display("FAIL reset_rvalid: got %b want 0", rvalid);   else n_pass++;
        n_total++; if (rdata !== 32'h0)   $display("FAIL reset_rdata: got %h want 0", rdata);     else n_pass++;
        n_total++; if (waitreq !== 1'b0)  $display("FAIL reset_waitreq: got %b want 0", waitreq); else n_pass++;
    endtask

    task automatic test_led_rw();
        logic [31:0] d; logic v;
        bus_write(3'd0, 32'h5);
        tick();
        n_total++; if (leds !== 4'h5) $display("FAIL led_drive: got %h want 5", leds); else n_pass++;
        bus_read(3'd0, d, v);
        n_total++; if (v !== 1'b1 || d !== 32'h5) $display("FAIL led_read: got v=%b d=%h want v=1 d=00000005", v, d); else n_pass++;
        tick();
        n_total++; if (rvalid !== 1'b0 || rdata !== 32'h5) $display("FAIL read_hold: got v=%b d=%h want v=0 d=00000005", rvalid, rdata); else n_pass++;
        bus_read(3'd5, d, v);
        n_total++; if (v !== 1'b1 || d !== 32'h0) $display("FAIL unmapped_read: got v=%b d=%h want v=1 d=0", v, d); else n_pass++;
        bus_read(3'd2, d, v);
        n_total++; if (d !== 32'h0002_0000) $display("FAIL status_empty: got %h want 00020000", d); else n_pass++;
    endtask

    task automatic test_blink();
        logic [3:0] exp;
        bus_write(3'd1, 32'd4);
        bus_write(3'd0, 32'h1F);
        for (int i = 0; i < 9; i++) begin
            tick();
            exp = (i >= 4 && i < 8) ? 4'h0 : 4'hF;
            n_total++; if (leds !== exp) $display("FAIL blink_cycle%0d: got %h want %h", i, leds, exp); else n_pass++;
        end
        bus_write(3'd1, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (leds !== 4'hF) $display("FAIL blink_off%0d: got %h want f", i, leds); else n_pass++;
        end
    endtask

    task automatic test_fifo_stall();
        logic [31:0] d; logic v;
        tlm_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_write(3'd3, 32'hA0 + 32'(i));
        bus_read(3'd2, d, v);
        n_total++; if (d !== 32'h0001_0008) $display("FAIL status_full: got %h want 00010008", d); else n_pass++;
        avs_address = 3'd3; avs_writedata = 32'hA8; avs_write = 1'b1;
        #1;
        n_total++; if (waitreq !== 1'b1) $display("FAIL stall_assert: got %b want 1", waitreq); else n_pass++;
        tick(); tick();
        n_total++; if (waitreq !== 1'b1 || tdata !== 32'hA0) $display("FAIL stall_hold: got w=%b head=%h want w=1 head=a0", waitreq, tdata); else n_pass++;
        tlm_ready = 1'b1;
        #1;
        n_total++; if (waitreq !== 1'b0) $display("FAIL stall_release: got %b want 0", waitreq); else n_pass++;
        tick();
        avs_write = 1'b0; tlm_ready = 1'b0;
        bus_read(3'd2, d, v);
        n_total++; if (d !== 32'h0001_0008) $display("FAIL status_after_swap: got %h want 00010008", d); else n_pass++;
        tlm_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            n_total++; if (tvalid !== 1'b1 || tdata !== 32'hA0 + 32'(i)) $display("FAIL drain_a%0d: got v=%b d=%h want v=1 d=%h", i, tvalid, tdata, 32'hA0 + 32'(i)); else n_pass++;
            tick();
        end
        tlm_ready = 1'b0;
        n_total++; if (tvalid !== 1'b0) $display("FAIL drained_empty: got %b want 0", tvalid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic v;
        for (int i = 0; i < 3; i++) bus_write(3'd3, 32'hC0 + 32'(i));
        tlm_ready = 1'b1;
        bus_write(3'd3, 32'hC3);
        tlm_ready = 1'b0;
        bus_read(3'd2, d, v);
        n_total++; if (d !== 32'h0000_0003) $display("FAIL pushpop_count: got %h want 00000003", d); else n_pass++;
        tlm_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            n_total++; if (tdata !== 32'hC0 + 32'(i)) $display("FAIL pushpop_order%0d: got %h want %h", i, tdata, 32'hC0 + 32'(i)); else n_pass++;
            tick();
        end
        tlm_ready = 1'b0;
        bus_write(3'd4, 32'h1234_5678);
        avs_address = 3'd4; avs_writedata = 32'hDEAD_BEEF; avs_read = 1'b1; avs_write = 1'b1;
        tick();
        avs_read = 1'b0; avs_write = 1'b0;
        n_total++; if (rvalid !== 1'b1 || rdata !== 32'h1234_5678) $display("FAIL rw_same_cycle: got v=%b d=%h want v=1 d=12345678", rvalid, rdata); else n_pass++;
        bus_read(3'd4, d, v);
        n_total++; if (d !== 32'hDEAD_BEEF) $display("FAIL scratch_new: got %h want deadbeef", d); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic v;
        sel = 1'b1;
        tlm_ready = 1'b0;
        for (int i = 0; i < 9; i++) bus_write(3'd3, 32'hB0 + 32'(i));
        bus_read(3'd2, d, v);
        n_total++; if (d !== 32'h0005_0008) $display("FAIL ovf_set: got %h want 00050008", d); else n_pass++;
        bus_write(3'd2, 32'h0004_0000);
        bus_read(3'd2, d, v);
        n_total++; if (d !== 32'h0001_0008) $display("FAIL ovf_clear: got %h want 00010008", d); else n_pass++;
        tlm_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (tdata !== 32'hB0 + 32'(i)) $display("FAIL drop_order%0d: got %h want %h", i, tdata, 32'hB0 + 32'(i)); else n_pass++;
            tick();
        end
        tlm_ready = 1'b0;
        n_total++; if (tvalid !== 1'b0) $display("FAIL drop_empty: got %b want 0", tvalid); else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v;
        bus_write(3'd0, 32'h3);
        bus_write(3'd3, 32'hD0);
        bus_write(3'd3, 32'hD1);
        n_total++; if (leds !== 4'h3) $display("FAIL pre_reset_leds: got %h want 3", leds); else n_pass++;
        tlm_ready = 1'b1;
        avs_address = 3'd4; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        n_total++; if (rvalid !== 1'b1 || tvalid !== 1'b1) $display("FAIL pre_reset_busy: got rv=%b tv=%b want 1 1", rvalid, tvalid); else n_pass++;
        reset_reset = 1'b1;
        #1;
        n_total++; if (tvalid !== 1'b0 || rvalid !== 1'b0 || leds !== 4'h0 || rdata !== 32'h0)
            $display("FAIL mid_reset: got tv=%b rv=%b leds=%h d=%h want 0 0 0 0", tvalid, rvalid, leds, rdata); else n_pass++;
        tlm_ready = 1'b0;
        tick(); tick();
        reset_reset = 1'b0;
        tick();
        bus_read(3'd2, d, v);
        n_total++; if (d !== 32'h0002_0000) $display("FAIL post_reset_status: got %h want 00020000", d); else n_pass++;
        bus_read(3'd4, d, v);
        n_total++; if (d !== 32'h0) $display("FAIL post_reset_scratch: got %h want 0", d); else n_pass++;
    endtask

    initial begin
        reset_reset = 1'b1;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        tlm_ready = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_reset = 1'b0;
        tick();
        test_reset();
        test_led_rw();
        test_blink();
        test_fifo_stall();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
